// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin access to a shared bank of master-slave SR flags.
// Ports: clk, rst_n, req/req_s/req_r/req_idx in; gnt, busy, conflict, q, q_bar out.
module sr_flag_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_s,
  input  logic [NUM_REQ-1:0]       req_r,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     conflict,
  output logic [NUM_FLAGS-1:0]     q,
  output logic [NUM_FLAGS-1:0]     q_bar
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     win_id;
  logic [PTR_W-1:0]     win_sel;
  logic                 win_found;
  logic                 win_s;
  logic                 win_r;
  logic [IDX_W-1:0]     win_idx;
  logic                 lat_s;
  logic                 lat_r;
  logic [IDX_W-1:0]     lat_idx;
  logic                 master;
  logic                 master_d;
  logic                 cur_bit;
  logic [NUM_FLAGS-1:0] wr_mask;

  // Scan upward from rr_ptr, wrapping, and take the first live request.
  always_comb begin
    int k;
    k         = 0;
    win_found = 1'b0;
    win_sel   = '0;
    win_s     = 1'b0;
    win_r     = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_found && req[k]) begin
        win_found = 1'b1;
        win_sel   = PTR_W'(k);
        win_s     = req_s[k];
        win_r     = req_r[k];
        win_idx   = req_idx[k*IDX_W +: IDX_W];
      end
    end
  end

  // An out-of-range index decodes to an empty mask, so nothing is written.
  always_comb begin
    wr_mask = '0;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      wr_mask[f] = (int'(lat_idx) == f);
    end
  end

  assign cur_bit = |(q & wr_mask);

  always_comb begin
    master_d = cur_bit;
    unique case (1'b1)
      (lat_s & ~lat_r): master_d = 1'b1;
      (~lat_s & lat_r): master_d = 1'b0;
      default:          master_d = cur_bit;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = CAPTURE;
      CAPTURE: state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      conflict <= 1'b0;
      q        <= '0;
      rr_ptr   <= '0;
      win_id   <= '0;
      lat_s    <= 1'b0;
      lat_r    <= 1'b0;
      lat_idx  <= '0;
      master   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          gnt <= '0;
          if (win_found) begin
            win_id  <= win_sel;
            lat_s   <= win_s;
            lat_r   <= win_r;
            lat_idx <= win_idx;
            gnt     <= NUM_REQ'(1) << win_sel;
          end
        end
        CAPTURE: begin
          gnt      <= '0;
          master   <= master_d;
          conflict <= lat_s & lat_r;
        end
        COMMIT: begin
          q        <= (q & ~wr_mask)
                    | ({NUM_FLAGS{master}} & wr_mask);
          conflict <= 1'b0;
          rr_ptr   <= (win_id == PTR_W'(NUM_REQ-1))
                    ? '0 : win_id + PTR_W'(1);
        end
        default: gnt <= '0;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign q_bar = ~q;

endmodule
